gate_op_arbiter: RTL and testbench

- Shares a single registered bitwise logic-operation unit between two requesters: AND, OR, NOT, NAND, NOR, XOR, XNOR on WIDTH-bit operands.
- Round-robin arbitration, valid/ready handshakes on both request ports and on the result port, one-entry output register.
- Saturating per-requester accept counters for bring-up and debug.
- Sits between lab-level stimulus sources (switch/FSM drivers) and the result display/checker logic.

---
 rtl/gate_op_arbiter.sv | 157 +++++++++++++++
 tb/tb_gate_op_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_op_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gate_op_arbiter
//  Purpose  : Two-requester round-robin front end to one registered bitwise
//             logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) with a one-entry
//             result register and saturating per-requester accept counters.
//  Revision : 1.0  initial release
// ============================================================================
module gate_op_arbiter #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_id,
   output logic             res_err,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   localparam logic [2:0]       OP_AND     = 3'd0;
   localparam logic [2:0]       OP_OR      = 3'd1;
   localparam logic [2:0]       OP_NOT     = 3'd2;
   localparam logic [2:0]       OP_NAND    = 3'd3;
   localparam logic [2:0]       OP_NOR     = 3'd4;
   localparam logic [2:0]       OP_XOR     = 3'd5;
   localparam logic [2:0]       OP_XNOR    = 3'd6;
   localparam logic [2:0]       OP_ILLEGAL = 3'd7;
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_t;

   slot_t            slot_q, slot_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_id_q, res_id_d;
   logic             res_err_q, res_err_d;
   logic             ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   logic             slot_free;
   logic             grant;
   logic             acc0;
   logic             acc1;
   logic [2:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [WIDTH-1:0] alu_y;

   // Round-robin grant: a lone requester wins, a tie goes to the pointer.
   always_comb begin
      slot_free  = (slot_q == SLOT_EMPTY) || res_ready;
      grant      = (req0_valid && req1_valid) ? ptr_q : req1_valid;
      req0_ready = slot_free && !grant && !rst;
      req1_ready = slot_free &&  grant && !rst;
      acc0       = req0_valid && req0_ready;
      acc1       = req1_valid && req1_ready;
   end

   // Operand steering and the shared bitwise logic unit.
   always_comb begin
      sel_op = grant ? req1_op : req0_op;
      sel_a  = grant ? req1_a  : req0_a;
      sel_b  = grant ? req1_b  : req0_b;
      case (sel_op)
         OP_AND:  alu_y = sel_a & sel_b;
         OP_OR:   alu_y = sel_a | sel_b;
         OP_NOT:  alu_y = ~sel_a;
         OP_NAND: alu_y = ~(sel_a & sel_b);
         OP_NOR:  alu_y = ~(sel_a | sel_b);
         OP_XOR:  alu_y = sel_a ^ sel_b;
         OP_XNOR: alu_y = ~(sel_a ^ sel_b);
         default: alu_y = '0;
      endcase
   end

   // Next-state: load on accept, otherwise empty the slot when drained.
   always_comb begin
      slot_d     = slot_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      res_err_d  = res_err_q;
      ptr_d      = ptr_q;
      cnt0_d     = cnt0_q;
      cnt1_d     = cnt1_q;
      if (acc0 || acc1) begin
         slot_d     = SLOT_FULL;
         res_data_d = alu_y;
         res_id_d   = acc1;
         res_err_d  = (sel_op == OP_ILLEGAL);
         ptr_d      = !acc1;
      end else if ((slot_q == SLOT_FULL) && res_ready) begin
         slot_d = SLOT_EMPTY;
      end
      if (acc0 && (cnt0_q != CNT_MAX)) begin
         cnt0_d = cnt0_q + 1'b1;
      end
      if (acc1 && (cnt1_q != CNT_MAX)) begin
         cnt1_d = cnt1_q + 1'b1;
      end
   end

   // State registers; reset drops any held result and re-favours requester 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q     <= SLOT_EMPTY;
         res_data_q <= '0;
         res_id_q   <= 1'b0;
         res_err_q  <= 1'b0;
         ptr_q      <= 1'b0;
         cnt0_q     <= '0;
         cnt1_q     <= '0;
      end else begin
         slot_q     <= slot_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         res_err_q  <= res_err_d;
         ptr_q      <= ptr_d;
         cnt0_q     <= cnt0_d;
         cnt1_q     <= cnt1_d;
      end
   end

   assign res_valid = (slot_q == SLOT_FULL);
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign res_err   = res_err_q;
   assign cnt0      = cnt0_q;
   assign cnt1      = cnt1_q;

   // Requesters must hold a pending operation unchanged until it is taken.
   a_hold0: assert property (@(posedge clk) disable iff (rst)
      (req0_valid && !req0_ready) |=>
      (req0_valid && $stable(req0_op) && $stable(req0_a) && $stable(req0_b)));

   a_hold1: assert property (@(posedge clk) disable iff (rst)
      (req1_valid && !req1_ready) |=>
      (req1_valid && $stable(req1_op) && $stable(req1_a) && $stable(req1_b)));

endmodule
`default_nettype wire

// File: tb/tb_gate_op_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_op_arbiter
//  Purpose  : Self-checking bench for gate_op_arbiter: directed scenarios
//             followed by randomized traffic against a truth-table model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gate_op_arbiter;

   localparam int WIDTH   = 4;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             v     [2];
   logic [2:0]       op    [2];
   logic [WIDTH-1:0] a     [2];
   logic [WIDTH-1:0] b     [2];
   logic             res_ready;

   logic             req0_ready, req1_ready;
   logic             res_valid, res_id, res_err;
   logic [WIDTH-1:0] res_data;
   logic [CNT_W-1:0] cnt0, cnt1;

   // reference model state
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_id;
   logic             m_err;
   logic             m_ptr;
   int               m_cnt [2];
   logic             last_acc [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gate_op_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (v[0]),
      .req0_ready (req0_ready),
      .req0_op    (op[0]),
      .req0_a     (a[0]),
      .req0_b     (b[0]),
      .req1_valid (v[1]),
      .req1_ready (req1_ready),
      .req1_op    (op[1]),
      .req1_a     (a[1]),
      .req1_b     (b[1]),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_id     (res_id),
      .res_err    (res_err),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Each opcode described as a 2-input truth table indexed by {a_bit,b_bit}.
   function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
      logic [3:0]       tt;
      logic [WIDTH-1:0] r;
      case (o)
         3'd0:    tt = 4'b1000;
         3'd1:    tt = 4'b1110;
         3'd2:    tt = 4'b0011;
         3'd3:    tt = 4'b0111;
         3'd4:    tt = 4'b0001;
         3'd5:    tt = 4'b0110;
         3'd6:    tt = 4'b1001;
         default: tt = 4'b0000;
      endcase
      for (int i = 0; i < WIDTH; i++) r[i] = tt[{x[i], y[i]}];
      return r;
   endfunction

   // One clock: check at negedge, advance model at posedge, return at +1.
   task automatic step();
      logic sf, any, g, e0, e1, acc0, acc1;
      @(negedge clk);
      sf  = !m_valid || res_ready;
      any = v[0] || v[1];
      g   = (v[0] && v[1]) ? m_ptr : v[1];
      e0  = sf && !rst && any && !g;
      e1  = sf && !rst && any &&  g;
      if (any) begin
         chk("req0_ready", 32'(req0_ready), 32'(e0));
         chk("req1_ready", 32'(req1_ready), 32'(e1));
      end
      chk("res_valid", 32'(res_valid), 32'(m_valid));
      chk("res_data",  32'(res_data),  32'(m_data));
      chk("res_id",    32'(res_id),    32'(m_id));
      chk("res_err",   32'(res_err),   32'(m_err));
      chk("cnt0",      32'(cnt0),      32'(m_cnt[0]));
      chk("cnt1",      32'(cnt1),      32'(m_cnt[1]));
      acc0 = v[0] && e0;
      acc1 = v[1] && e1;
      @(posedge clk);
      if (rst) begin
         m_valid  = 1'b0;
         m_data   = '0;
         m_id     = 1'b0;
         m_err    = 1'b0;
         m_ptr    = 1'b0;
         m_cnt[0] = 0;
         m_cnt[1] = 0;
         acc0     = 1'b0;
         acc1     = 1'b0;
      end else if (acc0 || acc1) begin
         m_valid = 1'b1;
         m_id    = acc1;
         m_data  = ref_op(op[acc1], a[acc1], b[acc1]);
         m_err   = (op[acc1] == 3'd7);
         m_ptr   = !acc1;
         if (m_cnt[acc1] < CNT_MAX) m_cnt[acc1]++;
      end else if (m_valid && res_ready) begin
         m_valid = 1'b0;
      end
      last_acc[0] = acc0;
      last_acc[1] = acc1;
      #1;
   endtask

   task automatic release_accepted();
      for (int n = 0; n < 2; n++) if (last_acc[n]) v[n] = 1'b0;
   endtask

   // Let pending requests complete, then go idle with an empty slot.
   task automatic drain();
      res_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         release_accepted();
         if (!v[0] && !v[1]) break;
         step();
      end
      chk("drain_pending", 32'(v[0] || v[1]), 32'd0);
      step();
   endtask

   initial begin
      logic [3:0] exp_tab [8];
      logic [WIDTH-1:0] hold_data;
      logic             hold_id;

      exp_tab = '{4'b1000, 4'b1110, 4'b0011, 4'b0111,
                  4'b0001, 4'b0110, 4'b1001, 4'b0000};
      rst = 1'b1; res_ready = 1'b0;
      for (int n = 0; n < 2; n++) begin
         v[n] = 1'b0; op[n] = '0; a[n] = '0; b[n] = '0; last_acc[n] = 1'b0; m_cnt[n] = 0;
      end
      m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_err = 1'b0; m_ptr = 1'b0;

      // reset
      step(); step();
      rst = 1'b0;
      step();

      // single op from requester 0
      res_ready = 1'b1;
      v[0] = 1'b1; op[0] = 3'd0; a[0] = 4'b1100; b[0] = 4'b1010;
      step();
      v[0] = 1'b0;
      chk("single_valid", 32'(res_valid), 32'd1);
      chk("single_data",  32'(res_data),  32'b1000);
      chk("single_id",    32'(res_id),    32'd0);
      chk("single_err",   32'(res_err),   32'd0);
      chk("single_cnt0",  32'(cnt0),      32'd1);
      step();

      // every opcode back to back from requester 1
      v[1] = 1'b1; a[1] = 4'b1100; b[1] = 4'b1010;
      for (int k = 0; k < 8; k++) begin
         op[1] = 3'(k);
         step();
         chk("opmap_data", 32'(res_data), 32'(exp_tab[k]));
         chk("opmap_err",  32'(res_err),  32'(k == 7));
      end
      v[1] = 1'b0;
      chk("opmap_cnt1", 32'(cnt1), 32'd8);
      step();

      // contention: alternating grants starting with requester 0
      v[0] = 1'b1; op[0] = 3'd5; a[0] = 4'b0101; b[0] = 4'b0011;
      v[1] = 1'b1; op[1] = 3'd1; a[1] = 4'b1000; b[1] = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("cont_id", 32'(res_id), 32'(k % 2));
      end
      drain();

      // backpressure then simultaneous drain and accept
      v[0] = 1'b1; op[0] = 3'd6; a[0] = 4'b1111; b[0] = 4'b0110;
      v[1] = 1'b1; op[1] = 3'd3; a[1] = 4'b1010; b[1] = 4'b1001;
      step();
      res_ready = 1'b0;
      hold_data = res_data;
      hold_id   = res_id;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("bp_data", 32'(res_data), 32'(hold_data));
         chk("bp_id",   32'(res_id),   32'(hold_id));
      end
      res_ready = 1'b1;
      step();
      chk("bp_valid", 32'(res_valid), 32'd1);
      drain();

      // counter saturation on requester 0
      v[0] = 1'b1; op[0] = 3'd2; a[0] = 4'b0110; b[0] = 4'b0000;
      for (int k = 0; k < CNT_MAX + 5; k++) step();
      chk("sat_cnt0", 32'(cnt0), 32'(CNT_MAX));
      drain();

      // reset while full and stalled
      res_ready = 1'b0;
      v[0] = 1'b1; op[0] = 3'd4; a[0] = 4'b0001; b[0] = 4'b0100;
      v[1] = 1'b1; op[1] = 3'd0; a[1] = 4'b1111; b[1] = 4'b1111;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_cnt0",  32'(cnt0),      32'd0);
      chk("rst_cnt1",  32'(cnt1),      32'd0);
      step();
      chk("rst_grant_id", 32'(res_id), 32'd0);
      chk("rst_grant_cnt0", 32'(cnt0), 32'd1);
      drain();

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst       = ($urandom_range(149) == 0);
         res_ready = ($urandom_range(3) != 0);
         for (int n = 0; n < 2; n++) begin
            if (!v[n] || last_acc[n]) begin
               v[n]  = ($urandom_range(2) != 0);
               op[n] = 3'($urandom_range(7));
               a[n]  = WIDTH'($urandom);
               b[n]  = WIDTH'($urandom);
            end
         end
         step();
      end
      rst = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
